// File: rtl/register_file_mp_if.sv
// register_file_mp_if: bus bundle for the multi-read-port register file.
// Carries the write port, the packed read ports and the clear handshake.
// The master side (core or testbench) drives addresses, data and requests;
// the slave side (the register file) returns read data and busy status.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                     write_enable_i;
  logic [AW-1:0]            write_addr_i;
  logic [DATA_W-1:0]        write_data_i;
  logic [NUM_RD*AW-1:0]     read_addr_i;
  logic [NUM_RD*DATA_W-1:0] read_data_o;
  logic                     clear_req_i;
  logic                     busy_o;

  modport master (
    output write_enable_i,
    output write_addr_i,
    output write_data_i,
    output read_addr_i,
    output clear_req_i,
    input  read_data_o,
    input  busy_o
  );

  modport slave (
    input  write_enable_i,
    input  write_addr_i,
    input  write_data_i,
    input  read_addr_i,
    input  clear_req_i,
    output read_data_o,
    output busy_o
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised register file with NUM_RD combinational
// read ports, one synchronous write port, an optional hardwired zero entry
// and a clear sequencer that zeroes every entry after reset or on request.
//
// Optional feature: define RF_BYPASS_EN to forward write_data_i to any read
// port whose address matches a write taking effect in the same cycle.
// Without it, a same-cycle read returns the stored (old) value.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  register_file_mp_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic              busy_q;
  logic              write_fire_d;

  // NOTE: the storage array has no reset; clearing it is the job of the
  // sweep below, which keeps the array a plain RAM-style structure.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // A user write takes effect only when idle and not aimed at the zero entry.
  assign write_fire_d = bus.write_enable_i && !busy_q &&
                        !((ZERO_REG == 1) && (bus.write_addr_i == '0));

  assign bus.busy_o = busy_q;

  // Clear sequencer: reset or an idle clear request starts a full sweep.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clear_req_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          // Requests during the sweep are ignored; it runs to completion.
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Storage update: sweep zeroes one entry per edge, otherwise user writes.
  always_ff @(posedge clk_i) begin
    if (busy_q) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (write_fire_d) begin
      mem_q[bus.write_addr_i] <= bus.write_data_i;
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] rdata;

    assign raddr = bus.read_addr_i[k*AW +: AW];

    // Port k read mux: stored value, zero entry, optional bypass, busy mask.
    // NOTE: rdata is assigned a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
      rdata = mem_q[raddr];
      if ((ZERO_REG == 1) && (raddr == '0)) begin
        rdata = '0;
      end
`ifdef RF_BYPASS_EN
      if (write_fire_d && (raddr == bus.write_addr_i)) begin
        rdata = bus.write_data_i;
      end
`else
`endif
      if (busy_q) begin
        rdata = '0;
      end
    end

    assign bus.read_data_o[k*DATA_W +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed bench for register_file_mp.
// dut  : default build (32x32, 2 read ports, zero entry enabled).
// dut2 : 16x64, 4 read ports, no zero entry.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus ();
  register_file_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) bus2 ();

  register_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  register_file_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG(0)) dut2 (
    .clk_i (clk),
    .rst_i (rst2),
    .bus   (bus2)
  );

`ifdef RF_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000_0055;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls on dut (bounded).
  task automatic count_busy(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus.busy_o && edges < 200);
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    bus.write_enable_i = 1'b1;
    bus.write_addr_i   = a;
    bus.write_data_i   = d;
    tick();
    bus.write_enable_i = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    rst = 1'b1;
    tick();
    tick();
    bus.read_addr_i = {5'd7, 5'd3};
    #1;
    n_total++;
    if (bus.busy_o !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy_o);
    else n_pass++;
    n_total++;
    if (bus.read_data_o !== 64'h0) $display("FAIL reset_rdata: got %h want 0", bus.read_data_o);
    else n_pass++;
    rst = 1'b0;
    count_busy(edges);
    n_total++;
    if (edges !== 32) $display("FAIL reset_sweep_len: got %0d edges want 32", edges);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      bus.read_addr_i = {5'(31 - a), 5'(a)};
      #1;
      n_total++;
      if (bus.read_data_o !== 64'h0)
        $display("FAIL reset_clear_addr%0d: got %h want 0", a, bus.read_data_o);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    bus.read_addr_i = {5'd0, 5'd5};
    write1(5'd5, 32'hDEAD_BEEF);
    n_total++;
    if (bus.read_data_o[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL wr_addr5: got %h want deadbeef", bus.read_data_o[31:0]);
    else n_pass++;
    n_total++;
    if (bus.read_data_o[63:32] !== 32'h0)
      $display("FAIL wr_addr0_p1: got %h want 0", bus.read_data_o[63:32]);
    else n_pass++;
    write1(5'd0, 32'h0000_1234);
    bus.read_addr_i = {5'd5, 5'd0};
    #1;
    n_total++;
    if (bus.read_data_o[31:0] !== 32'h0)
      $display("FAIL zero_reg_write: got %h want 0", bus.read_data_o[31:0]);
    else n_pass++;
    n_total++;
    if (bus.read_data_o[63:32] !== 32'hDEAD_BEEF)
      $display("FAIL wr_addr5_p1: got %h want deadbeef", bus.read_data_o[63:32]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    write1(5'd9, 32'h0000_0011);
    bus.write_enable_i = 1'b1;
    bus.write_addr_i   = 5'd9;
    bus.write_data_i   = 32'h0000_0055;
    bus.read_addr_i    = {5'd9, 5'd5};
    #1;
    n_total++;
    if (bus.read_data_o[63:32] !== BYP_EXP)
      $display("FAIL same_cycle_p1: got %h want %h", bus.read_data_o[63:32], BYP_EXP);
    else n_pass++;
    n_total++;
    if (bus.read_data_o[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL same_cycle_p0: got %h want deadbeef", bus.read_data_o[31:0]);
    else n_pass++;
    tick();
    bus.write_enable_i = 1'b0;
    #1;
    n_total++;
    if (bus.read_data_o[63:32] !== 32'h0000_0055)
      $display("FAIL next_cycle_p1: got %h want 55", bus.read_data_o[63:32]);
    else n_pass++;
    // Same-cycle write to the zero entry never forwards.
    bus.write_enable_i = 1'b1;
    bus.write_addr_i   = 5'd0;
    bus.write_data_i   = 32'hFFFF_FFFF;
    bus.read_addr_i    = {5'd0, 5'd0};
    #1;
    n_total++;
    if (bus.read_data_o !== 64'h0)
      $display("FAIL zero_bypass: got %h want 0", bus.read_data_o);
    else n_pass++;
    tick();
    bus.write_enable_i = 1'b0;
  endtask

  task automatic test_busy_mask();
    int edges;
    write1(5'd7, 32'hA5A5_A5A5);
    bus.read_addr_i = {5'd3, 5'd7};
    #1;
    n_total++;
    if (bus.read_data_o[31:0] !== 32'hA5A5_A5A5)
      $display("FAIL pre_clear_addr7: got %h want a5a5a5a5", bus.read_data_o[31:0]);
    else n_pass++;
    bus.clear_req_i = 1'b1;
    tick();
    bus.clear_req_i = 1'b0;
    n_total++;
    if (bus.busy_o !== 1'b1) $display("FAIL clear_busy_rise: got %b want 1", bus.busy_o);
    else n_pass++;
    bus.write_enable_i = 1'b1;
    bus.write_addr_i   = 5'd3;
    bus.write_data_i   = 32'hFFFF_FFFF;
    edges = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.clear_req_i = (i == 5);
      tick();
      edges++;
    end
    bus.clear_req_i = 1'b0;
    n_total++;
    if (bus.read_data_o !== 64'h0)
      $display("FAIL busy_read_mask: got %h want 0", bus.read_data_o);
    else n_pass++;
    bus.write_enable_i = 1'b0;
    while (bus.busy_o && edges < 200) begin
      tick();
      edges++;
    end
    n_total++;
    if (edges !== 32) $display("FAIL clear_sweep_len: got %0d edges want 32", edges);
    else n_pass++;
    n_total++;
    if (bus.read_data_o !== 64'h0)
      $display("FAIL post_clear_3_7: got %h want 0", bus.read_data_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int edges;
    write1(5'd12, 32'h0000_CAFE);
    bus.clear_req_i = 1'b1;
    tick();
    bus.clear_req_i = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    bus.read_addr_i = {5'd12, 5'd31};
    #1;
    n_total++;
    if (bus.busy_o !== 1'b1) $display("FAIL mid_rst_busy: got %b want 1", bus.busy_o);
    else n_pass++;
    tick();
    rst = 1'b0;
    count_busy(edges);
    n_total++;
    if (edges !== 32) $display("FAIL mid_rst_sweep_len: got %0d edges want 32", edges);
    else n_pass++;
    n_total++;
    if (bus.read_data_o !== 64'h0)
      $display("FAIL mid_rst_cleared: got %h want 0", bus.read_data_o);
    else n_pass++;
  endtask

  task automatic test_param_sweep();
    int edges;
    logic [63:0] exp0;
    logic [63:0] exp15;
    exp0  = 64'h0123_4567_89AB_CDEF;
    exp15 = 64'hFEDC_BA98_7654_3210;
    n_total++;
    if (bus2.busy_o !== 1'b1) $display("FAIL p2_reset_busy: got %b want 1", bus2.busy_o);
    else n_pass++;
    rst2  = 1'b0;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus2.busy_o && edges < 200);
    n_total++;
    if (edges !== 16) $display("FAIL p2_sweep_len: got %0d edges want 16", edges);
    else n_pass++;
    bus2.read_addr_i    = {4'd0, 4'd0, 4'd0, 4'd0};
    bus2.write_enable_i = 1'b1;
    bus2.write_addr_i   = 4'd0;
    bus2.write_data_i   = exp0;
    tick();
    bus2.write_enable_i = 1'b1;
    bus2.write_addr_i   = 4'd15;
    bus2.write_data_i   = exp15;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus2.read_data_o[k*64 +: 64] !== exp0)
        $display("FAIL p2_addr0_port%0d: got %h want %h", k, bus2.read_data_o[k*64 +: 64], exp0);
      else n_pass++;
    end
    tick();
    bus2.write_enable_i = 1'b0;
    bus2.read_addr_i    = {4'd15, 4'd0, 4'd15, 4'd1};
    #1;
    n_total++;
    if (bus2.read_data_o !== {exp15, exp0, exp15, 64'h0})
      $display("FAIL p2_mixed_read: got %h want %h", bus2.read_data_o, {exp15, exp0, exp15, 64'h0});
    else n_pass++;
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.write_enable_i  = 1'b0;
    bus.write_addr_i    = '0;
    bus.write_data_i    = '0;
    bus.read_addr_i     = '0;
    bus.clear_req_i     = 1'b0;
    bus2.write_enable_i = 1'b0;
    bus2.write_addr_i   = '0;
    bus2.write_data_i   = '0;
    bus2.read_addr_i    = '0;
    bus2.clear_req_i    = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_busy_mask();
    test_reset_mid_sweep();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
